// File: rtl/display_frame_sequencer.sv
// Display frame sequencer: latches a message, gathers randomness beats, launches the
// display datapath and hands each rendered frame downstream, FRAMES_PER_MSG times per message.
//   state | meaning
//   IDLE  | waiting for a message configuration
//   FILL  | collecting randomness beats into dp_rnd
//   EVAL  | datapath evaluating; dp_pix captured on the last cycle
//   OUT   | frame presented on pix_data until accepted
module display_frame_sequencer #(
    parameter int WIDTH          = 120,
    parameter int HEIGHT         = 52,
    parameter int NB_SEGMENTS    = 56,
    parameter int RNDSIZE        = 9,
    parameter int RND_WORD       = 4,
    parameter int EVAL_LATENCY   = 2,
    parameter int FRAMES_PER_MSG = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic                      cfg_z,
    input  logic [NB_SEGMENTS-1:0]    cfg_msg,
    input  logic                      rnd_valid,
    output logic                      rnd_ready,
    input  logic [RND_WORD-1:0]       rnd_data,
    output logic                      dp_z,
    output logic [NB_SEGMENTS-1:0]    dp_msg,
    output logic [RNDSIZE-1:0]        dp_rnd,
    output logic                      dp_start,
    input  logic [WIDTH*HEIGHT-1:0]   dp_pix,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic [WIDTH*HEIGHT-1:0]   pix_data,
    input  logic                      abort,
    output logic                      busy,
    output logic [15:0]               frame_idx
);

    localparam int PIX_W  = WIDTH * HEIGHT;
    localparam int NBEATS = (RNDSIZE + RND_WORD - 1) / RND_WORD;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int EVAL_W = (EVAL_LATENCY > 1) ? $clog2(EVAL_LATENCY) : 1;
    localparam int MSG_W  = $clog2(FRAMES_PER_MSG + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(NBEATS - 1);
    localparam logic [EVAL_W-1:0] EVAL_LOAD  = EVAL_W'(EVAL_LATENCY - 1);
    localparam logic [MSG_W-1:0]  LAST_FRAME = MSG_W'(FRAMES_PER_MSG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_EVAL = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic                r_dp_z;
    logic [NB_SEGMENTS-1:0] r_dp_msg;
    logic [RNDSIZE-1:0]  r_dp_rnd;
    logic [RNDSIZE-1:0]  w_rnd_merged;
    logic [BEAT_W-1:0]   r_beat;
    logic [EVAL_W-1:0]   r_eval_cnt;
    logic [MSG_W-1:0]    r_msg_cnt;
    logic [PIX_W-1:0]    r_pix_data;
    logic [15:0]         r_frame_idx;

    logic                w_abort;
    logic                w_cfg_fire;
    logic                w_rnd_fire;
    logic                w_last_beat;
    logic                w_eval_done;
    logic                w_xfer;
    logic                w_msg_done;

    assign w_abort     = abort && (r_state != S_IDLE);
    assign w_cfg_fire  = cfg_valid && (r_state == S_IDLE);
    assign w_rnd_fire  = rnd_valid && (r_state == S_FILL) && !abort;
    assign w_last_beat = w_rnd_fire && (r_beat == LAST_BEAT);
    assign w_eval_done = (r_state == S_EVAL) && (r_eval_cnt == '0) && !abort;
    assign w_xfer      = (r_state == S_OUT) && pix_ready;
    assign w_msg_done  = w_xfer && (r_msg_cnt == LAST_FRAME);

    // Beat k lands at bit offset k*RND_WORD; bits past RNDSIZE-1 simply have no home.
    always_comb begin
        w_rnd_merged = r_dp_rnd;
        for (int i = 0; i < RNDSIZE; i++) begin
            if ((i / RND_WORD) == int'(r_beat)) begin
                w_rnd_merged[i] = rnd_data[i % RND_WORD];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_cfg_fire)  w_next_state = S_FILL;
            S_FILL: if (w_last_beat) w_next_state = S_EVAL;
            S_EVAL: if (r_eval_cnt == '0) w_next_state = S_OUT;
            S_OUT:  if (w_xfer)      w_next_state = w_msg_done ? S_IDLE : S_FILL;
            default:                 w_next_state = S_IDLE;
        endcase
        if (w_abort) begin
            w_next_state = S_IDLE;
        end
    end

    always_comb begin
        cfg_ready = (r_state == S_IDLE);
        rnd_ready = (r_state == S_FILL);
        pix_valid = (r_state == S_OUT);
        busy      = (r_state != S_IDLE);
        dp_start  = (r_state == S_EVAL) && (r_eval_cnt == EVAL_LOAD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dp_z    <= 1'b0;
            r_dp_msg  <= '0;
            r_msg_cnt <= '0;
        end else if (w_cfg_fire) begin
            r_dp_z    <= cfg_z;
            r_dp_msg  <= cfg_msg;
            r_msg_cnt <= '0;
        end else if (w_xfer) begin
            r_msg_cnt <= r_msg_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dp_rnd <= '0;
            r_beat   <= '0;
        end else if (w_abort || w_cfg_fire) begin
            r_dp_rnd <= '0;
            r_beat   <= '0;
        end else if (w_rnd_fire) begin
            r_dp_rnd <= w_rnd_merged;
            r_beat   <= w_last_beat ? '0 : r_beat + 1'b1;
        end else if (w_xfer && !w_msg_done) begin
            r_dp_rnd <= '0;
            r_beat   <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_eval_cnt <= '0;
        end else if (w_last_beat) begin
            r_eval_cnt <= EVAL_LOAD;
        end else if ((r_state == S_EVAL) && (r_eval_cnt != '0)) begin
            r_eval_cnt <= r_eval_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pix_data <= '0;
        end else if (w_eval_done) begin
            r_pix_data <= dp_pix;
        end
    end

    // A transfer completing alongside abort still counts as delivered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_idx <= '0;
        end else if (w_xfer) begin
            r_frame_idx <= r_frame_idx + 16'd1;
        end
    end

    assign dp_z      = r_dp_z;
    assign dp_msg    = r_dp_msg;
    assign dp_rnd    = r_dp_rnd;
    assign pix_data  = r_pix_data;
    assign frame_idx = r_frame_idx;

endmodule

// File: tb/tb_display_frame_sequencer.sv
// Directed bench for display_frame_sequencer: a behavioural datapath drives dp_pix,
// expected frames are queued at stimulus time and checked when pix_valid appears.
module tb_display_frame_sequencer;

    localparam int WIDTH          = 120;
    localparam int HEIGHT         = 52;
    localparam int NB_SEGMENTS    = 56;
    localparam int RNDSIZE        = 9;
    localparam int RND_WORD       = 4;
    localparam int EVAL_LATENCY   = 2;
    localparam int FRAMES_PER_MSG = 4;
    localparam int PIX_W          = WIDTH * HEIGHT;

    logic                   clk;
    logic                   rst_n;
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic                   cfg_z;
    logic [NB_SEGMENTS-1:0] cfg_msg;
    logic                   rnd_valid;
    logic                   rnd_ready;
    logic [RND_WORD-1:0]    rnd_data;
    logic                   dp_z;
    logic [NB_SEGMENTS-1:0] dp_msg;
    logic [RNDSIZE-1:0]     dp_rnd;
    logic                   dp_start;
    logic [PIX_W-1:0]       dp_pix;
    logic                   pix_valid;
    logic                   pix_ready;
    logic [PIX_W-1:0]       pix_data;
    logic                   abort;
    logic                   busy;
    logic [15:0]            frame_idx;

    display_frame_sequencer #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .NB_SEGMENTS(NB_SEGMENTS), .RNDSIZE(RNDSIZE),
        .RND_WORD(RND_WORD), .EVAL_LATENCY(EVAL_LATENCY), .FRAMES_PER_MSG(FRAMES_PER_MSG)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_z(cfg_z), .cfg_msg(cfg_msg),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
        .dp_z(dp_z), .dp_msg(dp_msg), .dp_rnd(dp_rnd), .dp_start(dp_start), .dp_pix(dp_pix),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .abort(abort), .busy(busy), .frame_idx(frame_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [RNDSIZE-1:0] rnd;
        logic               z;
        logic [15:0]        fidx;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_fidx = 16'h0000;

    function automatic logic [PIX_W-1:0] make_pix(input logic [RNDSIZE-1:0] rnd, input logic z);
        logic [31:0]      s;
        logic [PIX_W-1:0] p;
        s = (32'(rnd) * 32'h9E3779B1) ^ {31'h0, z} ^ 32'h1234_0000;
        for (int i = 0; i < PIX_W; i++) p[i] = s[i % 32] ^ 1'((i / 32) % 2);
        return p;
    endfunction

    // Behavioural datapath: frame is only valid on the cycle EVAL_LATENCY-1 after dp_start.
    int   dp_age = 0;
    logic pix_ok;
    always @(posedge clk) begin
        if (dp_start)                             dp_age <= 1;
        else if (dp_age != 0 && dp_age < EVAL_LATENCY) dp_age <= dp_age + 1;
        else                                      dp_age <= 0;
    end
    assign pix_ok = (EVAL_LATENCY == 1) ? dp_start : (dp_age == EVAL_LATENCY - 1);
    assign dp_pix = pix_ok ? make_pix(dp_rnd, dp_z) : '0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_cfg_ready"}, cfg_ready, 1);
        check({pfx, "_rnd_ready"}, rnd_ready, 0);
        check({pfx, "_pix_valid"}, pix_valid, 0);
        check({pfx, "_dp_start"},  dp_start, 0);
        check({pfx, "_busy"},      busy, 0);
        check({pfx, "_frame_idx"}, frame_idx, 0);
        check({pfx, "_dp_z"},      dp_z, 0);
        check({pfx, "_dp_msg"},    dp_msg, 0);
        check({pfx, "_dp_rnd"},    dp_rnd, 0);
        check({pfx, "_pix_zero"},  (pix_data === '0), 1);
    endtask

    task automatic send_cfg(input logic z, input logic [NB_SEGMENTS-1:0] msg);
        cfg_valid = 1'b1;
        cfg_z     = z;
        cfg_msg   = msg;
        tick();
        cfg_valid = 1'b0;
        check("cfg_accept_busy", busy, 1);
        check("cfg_ready_low", cfg_ready, 0);
        check("cfg_dp_z", dp_z, z);
        check("cfg_dp_msg", dp_msg, msg);
    endtask

    task automatic send_beats(input logic [3:0] b0, input logic [3:0] b1, input logic [3:0] b2,
                              input logic z);
        logic [11:0] packed_beats;
        exp_t        e;
        packed_beats = {b2, b1, b0};
        rnd_valid = 1'b1;
        rnd_data  = b0;
        tick();
        rnd_data  = b1;
        tick();
        check("fill_needs_all_beats", rnd_ready, 1);
        check("no_early_start", dp_start, 0);
        rnd_data  = b2;
        tick();
        rnd_valid = 1'b0;
        e.rnd  = packed_beats[RNDSIZE-1:0];
        e.z    = z;
        e.fidx = exp_fidx;
        sb.push_back(e);
    endtask

    task automatic collect(input int stall, input bit with_abort);
        int               n;
        int               starts;
        exp_t             e;
        logic [PIX_W-1:0] exp_pix;
        n = 0;
        starts = 0;
        while (!pix_valid && n < 20) begin
            starts += int'(dp_start);
            tick();
            n++;
        end
        check("pix_latency", n, EVAL_LATENCY);
        check("dp_start_pulses", starts, 1);
        e = sb.pop_front();
        exp_pix = make_pix(e.rnd, e.z);
        check("out_dp_rnd", dp_rnd, e.rnd);
        check("out_pix_data", (pix_data === exp_pix), 1);
        check("out_frame_idx", frame_idx, e.fidx);
        pix_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            tick();
            check("stall_pix_valid", pix_valid, 1);
            check("stall_pix_data", (pix_data === exp_pix), 1);
            check("stall_dp_rnd", dp_rnd, e.rnd);
        end
        pix_ready = 1'b1;
        abort     = with_abort;
        tick();
        pix_ready = 1'b0;
        abort     = 1'b0;
        exp_fidx  = exp_fidx + 16'd1;
        check("post_frame_idx", frame_idx, exp_fidx);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_z     = 1'b0;
        cfg_msg   = '0;
        rnd_valid = 1'b0;
        rnd_data  = '0;
        pix_ready = 1'b0;
        abort     = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        rst_n = 1'b1;
        tick();

        // Basic frame, then three more with backpressure; last one exercises truncation
        send_cfg(1'b1, '1);
        check("fill_rnd_ready", rnd_ready, 1);
        send_beats(4'hA, 4'h5, 4'h1, 1'b1);
        check("basic_dp_rnd", dp_rnd, 9'h15A);
        collect(10, 1'b0);
        send_beats(4'h7, 4'h2, 4'h0, 1'b1);
        collect(10, 1'b0);
        send_beats(4'hC, 4'h9, 4'h1, 1'b1);
        collect(10, 1'b0);
        send_beats(4'h3, 4'h0, 4'hF, 1'b1);
        check("trunc_dp_rnd", dp_rnd, 9'h103);
        collect(10, 1'b0);
        check("msg_done_cfg_ready", cfg_ready, 1);
        check("msg_done_busy", busy, 0);
        check("msg_done_frame_idx", frame_idx, 4);

        // Abort mid-FILL after two beats; the beat offered with abort is dropped
        send_cfg(1'b0, 56'hA5_5A5A_A5A5_5A5A);
        rnd_valid = 1'b1;
        rnd_data  = 4'h6;
        tick();
        rnd_data  = 4'h3;
        tick();
        rnd_data  = 4'hF;
        abort     = 1'b1;
        tick();
        rnd_valid = 1'b0;
        check("abort_idle", cfg_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_dp_rnd", dp_rnd, 0);
        check("abort_frame_idx", frame_idx, 4);
        check("abort_dp_msg_hold", dp_msg, 56'hA5_5A5A_A5A5_5A5A);

        // Abort in IDLE is ignored and a coincident cfg is accepted
        send_cfg(1'b0, 56'h12_3456_789A_BCDE);
        abort = 1'b0;
        send_beats(4'h2, 4'h4, 4'h1, 1'b0);
        check("rearm_dp_rnd", dp_rnd, 9'h142);
        collect(0, 1'b1);
        check("abort_xfer_idle", cfg_ready, 1);
        check("abort_xfer_busy", busy, 0);
        check("abort_xfer_frame_idx", frame_idx, 5);

        // Frame counter wrap
        tick();
        force dut.r_frame_idx = 16'hFFFF;
        tick();
        release dut.r_frame_idx;
        exp_fidx = 16'hFFFF;
        send_cfg(1'b1, 56'h00_0000_0000_0001);
        send_beats(4'h5, 4'hA, 4'h0, 1'b1);
        collect(2, 1'b0);
        check("wrap_frame_idx", frame_idx, 16'h0000);

        // Reset mid-OUT overrides abort and a pending transfer
        send_beats(4'h9, 4'h9, 4'h1, 1'b1);
        n = 0;
        while (!pix_valid && n < 20) begin
            tick();
            n++;
        end
        check("reached_out", pix_valid, 1);
        rst_n     = 1'b0;
        pix_ready = 1'b1;
        abort     = 1'b1;
        tick();
        check_reset_state("midout_reset");
        rst_n     = 1'b1;
        pix_ready = 1'b0;
        abort     = 1'b0;
        sb.delete();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/display_frame_sequencer.md
DISPLAY_FRAME_SEQUENCER -- requirements
Module: display_frame_sequencer

Interface
REQ-001 Parameter WIDTH, default 120: display width in pixels.
REQ-002 Parameter HEIGHT, default 52: display height in pixels.
REQ-003 Parameter NB_SEGMENTS, default 56: number of bitmap segments in the message.
REQ-004 Parameter RNDSIZE, default 9: width of the randomness vector fed to the display datapath.
REQ-005 Parameter RND_WORD, default 4: bits per randomness beat; 1 <= RND_WORD <= RNDSIZE.
REQ-006 Parameter EVAL_LATENCY, default 2: cycles between dp_start and a valid dp_pix; minimum 1.
REQ-007 Parameter FRAMES_PER_MSG, default 4: frames rendered per accepted message; minimum 1.
REQ-008 Reset is synchronous, active-low, and there is exactly one clock; no other clock or reset input SHALL exist.
REQ-009 Port clk, in, 1: the single clock; all state updates on its rising edge.
REQ-010 Port rst_n, in, 1: synchronous active-low reset.
REQ-011 Ports cfg_valid in 1, cfg_ready out 1, cfg_z in 1, cfg_msg in NB_SEGMENTS: message configuration handshake.
REQ-012 Ports rnd_valid in 1, rnd_ready out 1, rnd_data in RND_WORD: evaluator randomness stream.
REQ-013 Ports dp_z out 1, dp_msg out NB_SEGMENTS, dp_rnd out RNDSIZE, dp_start out 1, dp_pix in WIDTH*HEIGHT: display datapath drive and return.
REQ-014 Ports pix_valid out 1, pix_ready in 1, pix_data out WIDTH*HEIGHT: frame output handshake.
REQ-015 Ports abort in 1, busy out 1, frame_idx out 16: control and status.

Function
REQ-016 FSM states SHALL be IDLE, FILL, EVAL and OUT; busy SHALL be 1 in every state except IDLE.
REQ-017 In IDLE, cfg_ready SHALL be 1; when cfg_valid&cfg_ready, cfg_z/cfg_msg are latched into dp_z/dp_msg, the per-message frame count clears, and the FSM enters FILL; cfg_ready SHALL be 0 in all other states.
REQ-018 dp_z and dp_msg SHALL hold stable from capture until the next accepted cfg handshake.
REQ-019 In FILL, rnd_ready SHALL be 1; each accepted beat is placed LSB-first at bit offset k*RND_WORD, where k is the beat index.
REQ-020 FILL SHALL take NBEATS = ceil(RNDSIZE/RND_WORD) beats; last-beat bits above RNDSIZE-1 SHALL be discarded; the cycle after the last beat, the FSM enters EVAL.
REQ-021 dp_start SHALL pulse 1 for exactly the first EVAL cycle; dp_rnd SHALL be stable throughout EVAL and OUT.
REQ-022 EVAL SHALL last exactly EVAL_LATENCY cycles; on its last cycle dp_pix is registered into pix_data and the FSM enters OUT.
REQ-023 In OUT, pix_valid SHALL be 1 and pix_data stable until pix_valid&pix_ready.
REQ-024 On a completed pix transfer, frame_idx SHALL increment modulo 2^16 (0xFFFF wraps to 0x0000) and the per-message count increments.
REQ-025 After the transfer: if the per-message count equals FRAMES_PER_MSG, go to IDLE; otherwise return to FILL for a fresh dp_rnd, with the beat index reset.
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, clear pix_valid, the beat index and dp_rnd, and leave frame_idx unchanged.
REQ-027 An rnd beat accepted in an abort cycle SHALL be discarded.
REQ-028 A pix transfer completing in an abort cycle SHALL count as delivered, so frame_idx increments.
REQ-029 abort in IDLE SHALL have no effect, and a cfg handshake in that same cycle SHALL still be accepted.
REQ-030 The frame-completion decision of REQ-025 SHALL take priority over a simultaneous rnd_valid, since rnd_ready is 0 in OUT.

Reset
REQ-031 When rst_n=0 at a clock edge: state=IDLE, cfg_ready=1, rnd_ready=0, pix_valid=0, dp_start=0, busy=0, frame_idx=0, and dp_z, dp_msg, dp_rnd and pix_data all 0.
REQ-032 Reset SHALL override abort and all handshakes, including reset asserted mid-FILL or mid-OUT.

Verification
REQ-033 Basic frame: cfg_msg=all 1s, z=1; beats 0xA, 0x5, 0x1 with RNDSIZE=9, RND_WORD=4 -> dp_rnd=9'h15A; one dp_start pulse; pix_valid exactly EVAL_LATENCY+1 cycles after the last beat.
REQ-034 Truncation: last beat 0xF with RNDSIZE=9 -> only bit 8 set from that beat; bits above RNDSIZE-1 are absent.
REQ-035 Multi-frame with backpressure: FRAMES_PER_MSG=4 and pix_ready held low 10 cycles per frame -> pix_data stable while stalled, 4 transfers, frame_idx 0->4, then IDLE with cfg_ready=1.
REQ-036 Abort mid-FILL after 2 beats -> next cycle IDLE, dp_rnd=0, frame_idx unchanged; a new cfg is accepted and needs all 3 beats.
REQ-037 Abort coincident with pix_valid&pix_ready -> frame_idx increments by 1 and the FSM is in IDLE.
REQ-038 Wrap and reset: preload frame_idx to 0xFFFF via 65535 frames (or force) -> next frame gives 0x0000; rst_n=0 mid-OUT -> all REQ-031 values on the next cycle.
